nibble_serial_adder: RTL and testbench

Multi-cycle adder that adds two 4·NIBBLES-bit operands one nibble per cycle through the team's 4-bit `ripple_carry_adder`. A registered carry chains the nibbles, least significant first. The block sits directly upstream of that adder: it slices the operands, drives the adder's inputs, and collects its sum and carry-out. Valid/ready handshakes on both sides let it sit between a producer and a consumer of wide operands without a wide combinational carry path.

---
 rtl/nibble_serial_adder_if.sv | 32 +++
 rtl/nibble_serial_adder.sv | 138 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Handshake bundle for nibble_serial_adder.
// The producer side (in_*) and consumer side (out_*) share one interface
// so a single port connects the adder to its neighbours.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    // Seen from the adder: operands and out_ready come in, results go out.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

    // Seen from the surrounding logic that feeds and drains the adder.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one 4-bit ripple slice per clock, least
// significant nibble first, with the carry held in a register between
// slices so no wide carry chain exists.

// 4-bit ripple-carry adder slice used once per cycle by the serial adder.
module ripple_carry_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    // Bit-serial carry ripple through four full adders.
    always_comb begin
        logic w_c;
        w_c   = i_cin;
        o_sum = '0;
        for (int k = 0; k < 4; k++) begin
            o_sum[k] = i_a[k] ^ i_b[k] ^ w_c;
            w_c      = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
        end
        o_cout = w_c;
    end
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [W-1:0]  r_aCap;
    logic [W-1:0]  r_bCap;
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;

    logic [IW+1:0] w_base;
    logic [3:0]    w_aNib;
    logic [3:0]    w_bNib;
    logic [3:0]    w_sNib;
    logic          w_cNib;
    logic          w_lastNib;

    assign w_base    = {r_idx, 2'b00};
    assign w_aNib    = r_aCap[w_base +: 4];
    assign w_bNib    = r_bCap[w_base +: 4];
    assign w_lastNib = (r_idx == LAST_IDX);

    ripple_carry_adder u_rca (
        .i_a    (w_aNib),
        .i_b    (w_bNib),
        .i_cin  (r_carry),
        .o_sum  (w_sNib),
        .o_cout (w_cNib)
    );

    // State register; reset always lands in IDLE and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: accept in IDLE, walk the nibbles in RUN, hold in DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_nextState = RUN;
            RUN:     if (w_lastNib)     w_nextState = DONE;
            DONE:    if (bus.out_ready) w_nextState = IDLE;
            default:                    w_nextState = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then fold one nibble per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aCap  <= '0;
            r_bCap  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_aCap  <= bus.a;
                        r_bCap  <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                RUN: begin
                    r_sum[w_base +: 4] <= w_sNib;
                    r_carry            <= w_cNib;
                    if (w_lastNib) begin
                        r_cout <= w_cNib;
                        r_ovf  <= (r_aCap[W-1] ~^ r_bCap[W-1]) & (w_sNib[3] ^ r_aCap[W-1]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from registers only; rst forces them to their idle values.
    assign bus.in_ready  = ~rst & (r_state == IDLE);
    assign bus.out_valid = ~rst & (r_state == DONE);
    assign bus.busy      = ~rst & ((r_state == RUN) | (r_state == DONE));
    assign bus.sum       = rst ? '0 : r_sum;
    assign bus.cout      = ~rst & r_cout;
    assign bus.ovf       = ~rst & r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder with NIBBLES=4: directed corner
// cases, backpressure, mid-operation reset, then random operands.
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    nibble_serial_adder_if #(.NIBBLES(N)) busIf ();

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    always #5 clk = ~clk;

    exp_t sbQ[$];
    int   errCount   = 0;
    int   checkCount = 0;

    // Compare one observed value with the bench's expectation.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checkCount++;
        errCount++;
        $display("[TB] FAIL %s: timeout waiting for DUT", name);
    endtask

    // Reference: plain wide integer arithmetic, signed overflow by range test.
    function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t        e;
        logic [W:0]  full;
        longint      sa, sb, ss;
        longint      maxS, minS;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        ss     = sa + sb + longint'(cin);
        maxS   = (longint'(1) <<< (W - 1)) - 1;
        minS   = -(longint'(1) <<< (W - 1));
        e.ovf  = (ss > maxS) || (ss < minS);
        return e;
    endfunction

    // Monitor: pops and compares on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (busIf.out_valid && busIf.out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected result", 64'(busIf.sum), 64'hDEAD);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sum",  64'(busIf.sum),  64'(e.sum));
                    checkOutput("cout", 64'(busIf.cout), 64'(e.cout));
                    checkOutput("ovf",  64'(busIf.ovf),  64'(e.ovf));
                end
            end
        end
    end

    // One full transaction: accept, wait for result, optional hold, handshake.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input int hold, input bit junk, input bit checkLat);
        exp_t e;
        int   t;
        int   lat;
        t = 0;
        while (!busIf.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!busIf.in_ready) reportTimeout("in_ready");
        e = refModel(a, b, cin);
        busIf.in_valid = 1'b1;
        busIf.a        = a;
        busIf.b        = b;
        busIf.cin      = cin;
        sbQ.push_back(e);
        @(negedge clk);
        busIf.in_valid = 1'b0;
        busIf.a        = W'($urandom);
        busIf.b        = W'($urandom);
        busIf.cin      = 1'($urandom);
        if (checkLat) begin
            checkOutput("busy in RUN", 64'(busIf.busy), 64'd1);
            checkOutput("in_ready in RUN", 64'(busIf.in_ready), 64'd0);
        end
        lat = 0;
        while (!busIf.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!busIf.out_valid) begin
            reportTimeout("out_valid");
        end else if (checkLat) begin
            checkOutput("latency", 64'(lat), 64'd4);
        end
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                busIf.in_valid = 1'b1;
                busIf.a        = W'($urandom);
                busIf.b        = W'($urandom);
            end
            @(negedge clk);
            checkOutput("hold out_valid", 64'(busIf.out_valid), 64'd1);
            checkOutput("hold in_ready",  64'(busIf.in_ready),  64'd0);
            checkOutput("hold sum",       64'(busIf.sum),       64'(e.sum));
            checkOutput("hold cout",      64'(busIf.cout),      64'(e.cout));
        end
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b1;
        @(negedge clk);
        busIf.out_ready = 1'b0;
        checkOutput("in_ready after handshake",  64'(busIf.in_ready),  64'd1);
        checkOutput("out_valid after handshake", 64'(busIf.out_valid), 64'd0);
        checkOutput("sum held after handshake",  64'(busIf.sum),       64'(e.sum));
    endtask

    // Main sequence.
    initial begin
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;
        busIf.a         = '0;
        busIf.b         = '0;
        busIf.cin       = 1'b0;
        rst             = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset in_ready",  64'(busIf.in_ready),  64'd0);
        checkOutput("reset out_valid", 64'(busIf.out_valid), 64'd0);
        checkOutput("reset busy",      64'(busIf.busy),      64'd0);
        checkOutput("reset sum",       64'(busIf.sum),       64'd0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", 64'(busIf.in_ready), 64'd1);
        @(negedge clk);

        applyStimulus(16'h1234, 16'h1111, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1, 1'b0, 1'b0);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b0, 6, 1'b1, 1'b1);

        // Mid-operation reset after two RUN cycles; nothing queued for it.
        busIf.in_valid = 1'b1;
        busIf.a        = 16'hFFFF;
        busIf.b        = 16'hFFFF;
        busIf.cin      = 1'b1;
        @(negedge clk);
        busIf.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst in_ready", 64'(busIf.in_ready), 64'd0);
        checkOutput("rst busy",     64'(busIf.busy),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort out_valid", 64'(busIf.out_valid), 64'd0);
        checkOutput("abort sum",       64'(busIf.sum),       64'd0);
        checkOutput("abort cout",      64'(busIf.cout),      64'd0);
        checkOutput("abort ovf",       64'(busIf.ovf),       64'd0);
        checkOutput("abort busy",      64'(busIf.busy),      64'd0);
        checkOutput("abort in_ready",  64'(busIf.in_ready),  64'd1);
        @(negedge clk);
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 64'(sbQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
